// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-source result arbiter driving the common data bus; CDB_RR_EN selects round-robin instead of fixed LSB priority
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4
`endif

module cdb_arbiter #(
    parameter int TAG_W = `ROB_SIZE_LOG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jump_rst,

    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [TAG_W-1:0] alu_reorder,
    input  logic [31:0]      alu_value,
    input  logic             alu_jump,
    input  logic [31:0]      alu_target,

    input  logic             lsb_valid,
    output logic             lsb_ready,
    input  logic [TAG_W-1:0] lsb_reorder,
    input  logic [31:0]      lsb_value,

    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_reorder,
    output logic [31:0]      cdb_value,
    output logic             cdb_jump,
    output logic [31:0]      cdb_target
);

    // Cycle in which the arbiter may accept and broadcast results.
    logic active;
    assign active = !rst && !jump_rst && rdy;

    // One-entry hold slot per source.
    logic             hold_alu_valid_q,   hold_alu_valid_d;
    logic [TAG_W-1:0] hold_alu_reorder_q, hold_alu_reorder_d;
    logic [31:0]      hold_alu_value_q,   hold_alu_value_d;
    logic             hold_alu_jump_q,    hold_alu_jump_d;
    logic [31:0]      hold_alu_target_q,  hold_alu_target_d;

    logic             hold_lsb_valid_q,   hold_lsb_valid_d;
    logic [TAG_W-1:0] hold_lsb_reorder_q, hold_lsb_reorder_d;
    logic [31:0]      hold_lsb_value_q,   hold_lsb_value_d;

    // Registered bus outputs.
    logic             cdb_valid_q,   cdb_valid_d;
    logic [TAG_W-1:0] cdb_reorder_q, cdb_reorder_d;
    logic [31:0]      cdb_value_q,   cdb_value_d;
    logic             cdb_jump_q,    cdb_jump_d;
    logic [31:0]      cdb_target_q,  cdb_target_d;

`ifdef CDB_RR_EN
    // Source that received the most recent grant; 1 = ALU, 0 = LSB.
    localparam logic LG_ALU = 1'b1;
    localparam logic LG_LSB = 1'b0;
    logic last_grant_q, last_grant_d;
`endif

    logic grant_alu;
    logic grant_lsb;
    logic alu_fire;
    logic lsb_fire;

    // Pick at most one occupied slot to broadcast this cycle.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsb = 1'b0;
        if (active) begin
            if (hold_alu_valid_q && hold_lsb_valid_q) begin
`ifdef CDB_RR_EN
                grant_alu = (last_grant_q == LG_LSB);
                grant_lsb = (last_grant_q == LG_ALU);
`else
                grant_lsb = 1'b1;
`endif
            end else begin
                grant_alu = hold_alu_valid_q;
                grant_lsb = hold_lsb_valid_q;
            end
        end
    end

    // A slot can take a new result when empty or when it drains this cycle.
    always_comb begin
        alu_ready = active && (!hold_alu_valid_q || grant_alu);
        lsb_ready = active && (!hold_lsb_valid_q || grant_lsb);
        alu_fire  = alu_valid && alu_ready;
        lsb_fire  = lsb_valid && lsb_ready;
    end

    // Next state of hold slots, bus registers and grant history.
    always_comb begin
        hold_alu_valid_d   = hold_alu_valid_q;
        hold_alu_reorder_d = hold_alu_reorder_q;
        hold_alu_value_d   = hold_alu_value_q;
        hold_alu_jump_d    = hold_alu_jump_q;
        hold_alu_target_d  = hold_alu_target_q;
        hold_lsb_valid_d   = hold_lsb_valid_q;
        hold_lsb_reorder_d = hold_lsb_reorder_q;
        hold_lsb_value_d   = hold_lsb_value_q;
        cdb_valid_d        = cdb_valid_q;
        cdb_reorder_d      = cdb_reorder_q;
        cdb_value_d        = cdb_value_q;
        cdb_jump_d         = cdb_jump_q;
        cdb_target_d       = cdb_target_q;
`ifdef CDB_RR_EN
        last_grant_d       = last_grant_q;
`endif

        if (jump_rst) begin
            // Flush discards pending results but keeps the grant history.
            hold_alu_valid_d = 1'b0;
            hold_lsb_valid_d = 1'b0;
            cdb_valid_d      = 1'b0;
        end else if (rdy) begin
            if (alu_fire) begin
                hold_alu_valid_d   = 1'b1;
                hold_alu_reorder_d = alu_reorder;
                hold_alu_value_d   = alu_value;
                hold_alu_jump_d    = alu_jump;
                hold_alu_target_d  = alu_target;
            end else if (grant_alu) begin
                hold_alu_valid_d = 1'b0;
            end

            if (lsb_fire) begin
                hold_lsb_valid_d   = 1'b1;
                hold_lsb_reorder_d = lsb_reorder;
                hold_lsb_value_d   = lsb_value;
            end else if (grant_lsb) begin
                hold_lsb_valid_d = 1'b0;
            end

            if (grant_alu) begin
                cdb_valid_d   = 1'b1;
                cdb_reorder_d = hold_alu_reorder_q;
                cdb_value_d   = hold_alu_value_q;
                cdb_jump_d    = hold_alu_jump_q;
                cdb_target_d  = hold_alu_target_q;
`ifdef CDB_RR_EN
                last_grant_d  = LG_ALU;
`endif
            end else if (grant_lsb) begin
                // Loads never redirect the front end.
                cdb_valid_d   = 1'b1;
                cdb_reorder_d = hold_lsb_reorder_q;
                cdb_value_d   = hold_lsb_value_q;
                cdb_jump_d    = 1'b0;
                cdb_target_d  = 32'h0;
`ifdef CDB_RR_EN
                last_grant_d  = LG_LSB;
`endif
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset dominates flush and the global enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_alu_valid_q   <= 1'b0;
            hold_alu_reorder_q <= '0;
            hold_alu_value_q   <= 32'h0;
            hold_alu_jump_q    <= 1'b0;
            hold_alu_target_q  <= 32'h0;
            hold_lsb_valid_q   <= 1'b0;
            hold_lsb_reorder_q <= '0;
            hold_lsb_value_q   <= 32'h0;
            cdb_valid_q        <= 1'b0;
            cdb_reorder_q      <= '0;
            cdb_value_q        <= 32'h0;
            cdb_jump_q         <= 1'b0;
            cdb_target_q       <= 32'h0;
`ifdef CDB_RR_EN
            last_grant_q       <= LG_LSB;
`endif
        end else begin
            hold_alu_valid_q   <= hold_alu_valid_d;
            hold_alu_reorder_q <= hold_alu_reorder_d;
            hold_alu_value_q   <= hold_alu_value_d;
            hold_alu_jump_q    <= hold_alu_jump_d;
            hold_alu_target_q  <= hold_alu_target_d;
            hold_lsb_valid_q   <= hold_lsb_valid_d;
            hold_lsb_reorder_q <= hold_lsb_reorder_d;
            hold_lsb_value_q   <= hold_lsb_value_d;
            cdb_valid_q        <= cdb_valid_d;
            cdb_reorder_q      <= cdb_reorder_d;
            cdb_value_q        <= cdb_value_d;
            cdb_jump_q         <= cdb_jump_d;
            cdb_target_q       <= cdb_target_d;
`ifdef CDB_RR_EN
            last_grant_q       <= last_grant_d;
`endif
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_reorder = cdb_reorder_q;
    assign cdb_value   = cdb_value_q;
    assign cdb_jump    = cdb_jump_q;
    assign cdb_target  = cdb_target_q;

endmodule
